// File: rtl/alu_operand_sequencer_pkg.sv
// Shared types and constants for the ALU operand sequencer: state encoding,
// opcode values and the registered ALU result payload.
package alu_operand_sequencer_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned OP_W    = 2;
  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    WAIT_A  = 3'd0,
    WAIT_B  = 3'd1,
    WAIT_OP = 3'd2,
    EXEC    = 3'd3,
    DONE    = 3'd4
  } state_e;

  localparam state_e RESET_STATE = WAIT_A;

  localparam logic [OP_W-1:0] OP_ADD = 2'b00;
  localparam logic [OP_W-1:0] OP_SUB = 2'b01;
  localparam logic [OP_W-1:0] OP_AND = 2'b10;
  localparam logic [OP_W-1:0] OP_OR  = 2'b11;

  typedef struct packed {
    logic              carry;
    logic              zero;
    logic [DATA_W-1:0] result;
  } alu_out_t;

endpackage : alu_operand_sequencer_pkg

// File: rtl/alu_operand_sequencer_strobe_sync_edge.sv
// Synchronizes an asynchronous strobe into the clk domain and emits a
// registered one-cycle pulse on each synchronized rising edge.
module strobe_sync_edge #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   last_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q     <= '0;
      last_q     <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], async_in};
      last_q     <= sync_q[SYNC_STAGES-1];
      rise_pulse <= sync_q[SYNC_STAGES-1] & ~last_q;
    end
  end

endmodule : strobe_sync_edge

// File: rtl/alu_operand_sequencer.sv
// Front-end sequencer for the 8-bit ALU tile: captures A, B and opcode from a
// shared strobed bus, executes one 2-bit ALU operation and holds the result.
module alu_operand_sequencer
  import alu_operand_sequencer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic [DATA_W-1:0] data_in,
  input  logic              strobe_in,
  output logic [DATA_W-1:0] result_out,
  output logic              carry_out,
  output logic              zero_out,
  output logic              done,
  output logic              busy,
  output logic              timeout_err,
  output logic [STATE_W-1:0] state_dbg
);

  // Counter only ever holds 0..TIMEOUT_CYCLES-1; abort fires as it would reach the limit.
  localparam int unsigned CNT_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned CNT_LAST = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
  localparam bit          TO_EN    = (TIMEOUT_CYCLES != 0);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              timeout_err_d;
  logic              load_result;
  logic              stb_raw;
  logic              stb;
  logic              counting;
  logic              abort;
  alu_out_t          alu_res;

  strobe_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_strobe_sync (
    .clk       (clk),
    .rst_n     (rst_n),
    .async_in  (strobe_in),
    .rise_pulse(stb_raw)
  );

  // A disabled tile drops strobe pulses entirely.
  assign stb       = stb_raw & ena;
  assign state_dbg = state_q;

  // ALU datapath; only sampled into the output registers during EXEC.
  always_comb begin
    alu_res = '0;
    case (op_q)
      OP_ADD:  {alu_res.carry, alu_res.result} = {1'b0, a_q} + {1'b0, b_q};
      OP_SUB: begin
        alu_res.result = a_q - b_q;
        alu_res.carry  = (a_q < b_q);
      end
      OP_AND:  alu_res.result = a_q & b_q;
      default: alu_res.result = a_q | b_q;
    endcase
    alu_res.zero = (alu_res.result == '0);
  end

  // Next-state, operand capture and timeout control.
  always_comb begin
    state_d       = state_q;
    a_d           = a_q;
    b_d           = b_q;
    op_d          = op_q;
    cnt_d         = cnt_q;
    timeout_err_d = timeout_err;
    load_result   = 1'b0;
    counting      = (state_q == WAIT_B) || (state_q == WAIT_OP);
    abort         = TO_EN && ena && !stb && counting && (cnt_q == CNT_W'(CNT_LAST));

    if (ena) begin
      if (stb) begin
        cnt_d = '0;
      end else if (counting) begin
        cnt_d = cnt_q + CNT_W'(1);
      end

      case (state_q)
        WAIT_A: begin
          if (stb) begin
            a_d           = data_in;
            timeout_err_d = 1'b0;
            state_d       = WAIT_B;
          end
        end
        WAIT_B: begin
          if (stb) begin
            b_d     = data_in;
            state_d = WAIT_OP;
          end
        end
        WAIT_OP: begin
          if (stb) begin
            op_d    = data_in[OP_W-1:0];
            state_d = EXEC;
          end
        end
        EXEC: begin
          load_result = 1'b1;
          state_d     = DONE;
        end
        DONE: begin
          if (stb) begin
            a_d     = data_in;
            state_d = WAIT_B;
          end
        end
        default: state_d = RESET_STATE;
      endcase

      // A strobe in the same cycle as the limit takes priority (abort excludes stb).
      if (abort) begin
        state_d       = WAIT_A;
        timeout_err_d = 1'b1;
        cnt_d         = '0;
        a_d           = '0;
        b_d           = '0;
        op_d          = '0;
      end
    end
  end

  // State, operands and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= RESET_STATE;
      a_q         <= '0;
      b_q         <= '0;
      op_q        <= '0;
      cnt_q       <= '0;
      result_out  <= '0;
      carry_out   <= 1'b0;
      zero_out    <= 1'b0;
      done        <= 1'b0;
      busy        <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      b_q         <= b_d;
      op_q        <= op_d;
      cnt_q       <= cnt_d;
      timeout_err <= timeout_err_d;
      done        <= (state_d == DONE);
      busy        <= (state_d == WAIT_B) || (state_d == WAIT_OP) || (state_d == EXEC);
      if (load_result) begin
        result_out <= alu_res.result;
        carry_out  <= alu_res.carry;
        zero_out   <= alu_res.zero;
      end
    end
  end

endmodule : alu_operand_sequencer

// File: tb/tb_alu_operand_sequencer.sv
// Self-checking bench for alu_operand_sequencer: directed vector table,
// multi-cycle corner sequences and randomized operations against a reference model.
module tb_alu_operand_sequencer;

  localparam int unsigned TO = 10;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic [7:0] data_in;
  logic       strobe_in;
  logic [7:0] result_out;
  logic       carry_out;
  logic       zero_out;
  logic       done;
  logic       busy;
  logic       timeout_err;
  logic [2:0] state_dbg;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_operand_sequencer #(
    .SYNC_STAGES   (2),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ena        (ena),
    .data_in    (data_in),
    .strobe_in  (strobe_in),
    .result_out (result_out),
    .carry_out  (carry_out),
    .zero_out   (zero_out),
    .done       (done),
    .busy       (busy),
    .timeout_err(timeout_err),
    .state_dbg  (state_dbg)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] opb;
    logic [7:0] res;
    logic       cy;
    logic       z;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain integer arithmetic, returns {carry, zero, result}.
  function automatic logic [9:0] model(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    int ai, bi, r, c, o;
    ai = int'(a);
    bi = int'(b);
    o  = int'(opb) % 4;
    c  = 0;
    case (o)
      0: begin r = (ai + bi) % 256; c = ((ai + bi) > 255) ? 1 : 0; end
      1: begin r = (ai - bi + 256) % 256; c = (ai < bi) ? 1 : 0; end
      2: r = int'(a & b);
      default: r = int'(a | b);
    endcase
    return {c[0], (r == 0), 8'(r)};
  endfunction

  task automatic strobe_hi(input logic [7:0] b);
    data_in   = b;
    strobe_in = 1'b1;
    repeat (4) @(negedge clk);
    strobe_in = 1'b0;
  endtask

  task automatic strobe_lo();
    repeat (4) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    strobe_hi(b);
    strobe_lo();
  endtask

  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb);
    send(a);
    send(b);
    send(opb);
  endtask

  task automatic check_result(input string name, input logic [7:0] res, input logic cy, input logic z);
    check({name, ".result"}, 32'(result_out), 32'(res));
    check({name, ".carry"}, 32'(carry_out), 32'(cy));
    check({name, ".zero"}, 32'(zero_out), 32'(z));
    check({name, ".done"}, 32'(done), 32'd1);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".state"}, 32'(state_dbg), 32'd4);
  endtask

  task automatic check_all_zero(input string name);
    check({name, ".result"}, 32'(result_out), 32'd0);
    check({name, ".carry"}, 32'(carry_out), 32'd0);
    check({name, ".zero"}, 32'(zero_out), 32'd0);
    check({name, ".done"}, 32'(done), 32'd0);
    check({name, ".busy"}, 32'(busy), 32'd0);
    check({name, ".terr"}, 32'(timeout_err), 32'd0);
    check({name, ".state"}, 32'(state_dbg), 32'd0);
  endtask

  initial begin
    logic [9:0] exp;
    logic [7:0] ra, rb, rop;

    vecs[0] = '{8'd200, 8'd100, 8'h00, 8'h2C, 1'b1, 1'b0};
    vecs[1] = '{8'd5,   8'd7,   8'h01, 8'hFE, 1'b1, 1'b0};
    vecs[2] = '{8'hF0,  8'h0F,  8'hFE, 8'h00, 1'b0, 1'b1};
    vecs[3] = '{8'd3,   8'd4,   8'h03, 8'h07, 1'b0, 1'b0};
    vecs[4] = '{8'd1,   8'd1,   8'h00, 8'h02, 1'b0, 1'b0};
    vecs[5] = '{8'h80,  8'h80,  8'h00, 8'h00, 1'b1, 1'b1};
    vecs[6] = '{8'd9,   8'd9,   8'h01, 8'h00, 1'b0, 1'b1};
    vecs[7] = '{8'hAA,  8'h55,  8'h03, 8'hFF, 1'b0, 1'b0};
    vecs[8] = '{8'hFF,  8'h01,  8'h00, 8'h00, 1'b1, 1'b1};
    vecs[9] = '{8'h00,  8'hFF,  8'h01, 8'h01, 1'b1, 1'b0};

    rst_n     = 1'b0;
    ena       = 1'b1;
    strobe_in = 1'b0;
    data_in   = 8'h00;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // Exact latency: EXEC right after the opcode stb edge, DONE one edge later.
    send(vecs[0].a);
    send(vecs[0].b);
    strobe_hi(vecs[0].opb);
    check("lat.exec_state", 32'(state_dbg), 32'd3);
    check("lat.exec_done", 32'(done), 32'd0);
    check("lat.exec_busy", 32'(busy), 32'd1);
    @(negedge clk);
    check_result("v0", vecs[0].res, vecs[0].cy, vecs[0].z);
    strobe_lo();

    // Back-to-back from DONE: done drops on the A strobe.
    strobe_hi(vecs[1].a);
    check("b2b.done", 32'(done), 32'd0);
    check("b2b.state", 32'(state_dbg), 32'd1);
    check("b2b.busy", 32'(busy), 32'd1);
    strobe_lo();
    send(vecs[1].b);
    send(vecs[1].opb);
    check_result("v1", vecs[1].res, vecs[1].cy, vecs[1].z);

    for (int i = 2; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].opb);
      check_result($sformatf("v%0d", i), vecs[i].res, vecs[i].cy, vecs[i].z);
    end

    // Timeout: TO enabled cycles in WAIT_B after the A strobe abort the load.
    strobe_hi(8'h33);
    repeat (TO - 1) @(negedge clk);
    check("to.pre_state", 32'(state_dbg), 32'd1);
    check("to.pre_err", 32'(timeout_err), 32'd0);
    @(negedge clk);
    check("to.state", 32'(state_dbg), 32'd0);
    check("to.err", 32'(timeout_err), 32'd1);
    check("to.busy", 32'(busy), 32'd0);
    check("to.done", 32'(done), 32'd0);
    check("to.held_result", 32'(result_out), 32'(vecs[9].res));
    check("to.held_carry", 32'(carry_out), 32'(vecs[9].cy));
    strobe_hi(8'h11);
    check("to.clear_err", 32'(timeout_err), 32'd0);
    check("to.clear_state", 32'(state_dbg), 32'd1);
    strobe_lo();

    // Reset asserted while in WAIT_OP.
    send(8'h22);
    check("rst.in_wait_op", 32'(state_dbg), 32'd2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op(8'd3, 8'd4, 8'h03);
    check_result("after_rst", 8'h07, 1'b0, 1'b0);

    // Disabled tile ignores a strobe; the edge is lost for good.
    ena = 1'b0;
    send(8'h77);
    check("ena.state", 32'(state_dbg), 32'd4);
    check("ena.done", 32'(done), 32'd1);
    check("ena.result", 32'(result_out), 32'h07);
    ena = 1'b1;
    @(negedge clk);
    check("ena.state_after", 32'(state_dbg), 32'd4);
    run_op(8'd1, 8'd1, 8'h00);
    check_result("ena_op", 8'h02, 1'b0, 1'b0);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      ra  = 8'($urandom);
      rb  = 8'($urandom);
      rop = 8'($urandom);
      exp = model(ra, rb, rop);
      run_op(ra, rb, rop);
      check_result($sformatf("rnd%0d", i), exp[7:0], exp[9], exp[8]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_alu_operand_sequencer

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
Front-end sequencer for the 8-bit ALU tile. The tile has only one 8-bit input bus, so a host presents operand A, operand B and the opcode byte on that bus one after another, each qualified by a strobe pin. The block captures the three bytes, executes the 2-bit ALU operation and holds the registered result with carry and zero flags. It also raises a done indication back to the host.

Parameters:
SYNC_STAGES, 2, number of flops in the strobe_in synchronizer (minimum 2).
TIMEOUT_CYCLES, 255, clk cycles allowed between strobes during a partial load; 0 disables the timeout.

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
ena  input  1  tile enable; low freezes the block
data_in  input  8  shared operand/opcode bus from the host
strobe_in  input  1  asynchronous host strobe; the rising edge qualifies data_in
result_out  output  8  registered ALU result
carry_out  output  1  carry (ADD) or borrow (SUB); 0 for logic ops
zero_out  output  1  result_out == 0
done  output  1  result valid, held until the next load begins
busy  output  1  load or execution in progress
timeout_err  output  1  sticky flag: partial load aborted
state_dbg  output  3  FSM state encoding, for debug pins

Behaviour:
- Reset (async assert, sync release): state=WAIT_A; A, B, op, result_out, carry_out, zero_out, done, busy, timeout_err, timeout counter and synchronizer flops all 0.
- Strobe path: strobe_in passes through SYNC_STAGES flops, then a rising-edge detector produces a one-cycle stb pulse. data_in is sampled in the stb pulse cycle. The host holds data_in stable while strobe_in is high, with strobe high ≥ SYNC_STAGES+1 clk and low ≥ SYNC_STAGES+1 clk.
- FSM states and state_dbg encoding: WAIT_A=0, WAIT_B=1, WAIT_OP=2, EXEC=3, DONE=4.
  - WAIT_A + stb: A<=data_in, clear timeout_err, go to WAIT_B.
  - WAIT_B + stb: B<=data_in, go to WAIT_OP.
  - WAIT_OP + stb: op<=data_in[1:0] (bits 7:2 ignored), go to EXEC.
  - EXEC: unconditional, one cycle. Register result_out, carry_out and zero_out; set done; go to DONE.
  - DONE + stb: A<=data_in, clear done, go to WAIT_B (back-to-back operations need no extra strobe).
- Latency: done and the result are visible at the second rising edge after the opcode stb cycle.
- busy=1 in WAIT_B, WAIT_OP and EXEC, else 0. done=1 only in DONE.
- An stb pulse during EXEC is dropped, not queued.
- Arithmetic, all 8-bit unsigned, op select:
  - 00 ADD: {carry,result}=A+B (9-bit sum).
  - 01 SUB: result=A-B mod 256; carry=1 iff A<B.
  - 10 AND: carry=0.
  - 11 OR: carry=0.
  - zero_out=(result==0) for every op.
- Timeout, when TIMEOUT_CYCLES≠0:
  - The counter clears on every stb and counts every enabled cycle in WAIT_B and WAIT_OP.
  - When the counter reaches TIMEOUT_CYCLES: go to WAIT_A, set timeout_err, clear the counter. Any captured partial operands are discarded.
  - If a stb and the timeout fall in the same cycle, the stb wins.
  - result_out, carry_out and zero_out from the previous operation are held through an abort; done is already 0.
- ena=0: FSM, operand registers and counter are frozen; stb pulses are dropped; the synchronizer keeps running, so a strobe edge that occurs while disabled is lost. Outputs hold their values.
- Reset mid-operation: immediate return to the reset values; no partial result is exposed.

Decomposition:
- Shared package: state encoding constants (WAIT_A..DONE), opcode constants (OP_ADD=2'b00, OP_SUB=2'b01, OP_AND=2'b10, OP_OR=2'b11), and the reset state.
- One sub-module: strobe_sync_edge, with parameter SYNC_STAGES; inputs clk, rst_n, async_in; output rise_pulse.
- The ALU datapath stays a combinational case inside this block, registered only in EXEC.

Test Plan:
- Strobe A=200, B=100, op=0x00 → result_out=0x2C, carry_out=1, zero_out=0, done=1 two clk after the opcode stb; busy=0.
- From DONE, strobe A=5, B=7, op=0x01 → done drops on the A strobe; then result_out=0xFE, carry_out=1, zero_out=0.
- Strobe A=0xF0, B=0x0F, op=0xFE (treated as AND) → result_out=0x00, carry_out=0, zero_out=1.
- With TIMEOUT_CYCLES=10: strobe A only, then idle 10 cycles → state_dbg=0, timeout_err=1, previous result still held. Next A strobe clears timeout_err.
- Pulse rst_n low while in WAIT_OP → all outputs 0 and state_dbg=0 immediately; a fresh A/B/op=3,4,OR sequence then gives result_out=0x07.
- Hold ena=0 and strobe once → no state change. Raise ena and strobe A/B/op=1,1,ADD → result_out=0x02, carry_out=0.
